// File: rtl/apu_envelope_unit.sv
// APU volume envelope: reloadable divider clocking a 4-bit decay counter, restarted by a start flag.
// Optional debug taps (dbg_div, dbg_decay, dbg_start) are compiled in when ENV_DEBUG_EN is defined.
module apu_envelope_unit #(
    parameter int VOL_W = 4
) (
    input  logic             ACLK1,
    input  logic             n_res,
    input  logic             wr_reg0,
    input  logic             wr_reg3,
    input  logic [5:0]       din,
    input  logic             qframe,
    output logic [VOL_W-1:0] vol,
`ifdef ENV_DEBUG_EN
    output logic [VOL_W-1:0] dbg_div,
    output logic [VOL_W-1:0] dbg_decay,
    output logic             dbg_start,
`endif
    output logic             loop_q
);

    localparam logic [VOL_W-1:0] DECAY_MAX = {VOL_W{1'b1}};

    logic [VOL_W-1:0] v_reg;
    logic             const_reg;
    logic             loop_reg;
    logic             start_reg;
    logic [VOL_W-1:0] div_reg;
    logic [VOL_W-1:0] decay_reg;

    logic             start_nxt;
    logic [VOL_W-1:0] div_nxt;
    logic [VOL_W-1:0] decay_nxt;

    // Quarter-frame sequencing works on the pre-edge state; a register-3 write
    // in the same cycle wins over the start clear so the restart is not lost.
    always_comb begin
        start_nxt = start_reg;
        div_nxt   = div_reg;
        decay_nxt = decay_reg;
        if (qframe) begin
            if (start_reg) begin
                start_nxt = 1'b0;
                decay_nxt = DECAY_MAX;
                div_nxt   = v_reg;
            end else if (div_reg == '0) begin
                div_nxt = v_reg;
                if (decay_reg != '0) begin
                    decay_nxt = decay_reg - 1'b1;
                end else if (loop_reg) begin
                    decay_nxt = DECAY_MAX;
                end
            end else begin
                div_nxt = div_reg - 1'b1;
            end
        end
        if (wr_reg3) begin
            start_nxt = 1'b1;
        end
    end

    always_ff @(posedge ACLK1 or negedge n_res) begin
        if (!n_res) begin
            v_reg     <= '0;
            const_reg <= 1'b0;
            loop_reg  <= 1'b0;
            start_reg <= 1'b0;
            div_reg   <= '0;
            decay_reg <= '0;
        end else begin
            if (wr_reg0) begin
                v_reg     <= din[VOL_W-1:0];
                const_reg <= din[4];
                loop_reg  <= din[5];
            end
            start_reg <= start_nxt;
            div_reg   <= div_nxt;
            decay_reg <= decay_nxt;
        end
    end

    assign vol    = const_reg ? v_reg : decay_reg;
    assign loop_q = loop_reg;

`ifdef ENV_DEBUG_EN
    assign dbg_div   = div_reg;
    assign dbg_decay = decay_reg;
    assign dbg_start = start_reg;
`endif

endmodule

// File: tb/tb_apu_envelope_unit.sv
// Self-checking bench for apu_envelope_unit (default build, debug taps absent).
// Expected {loop_q, vol} values are queued when a cycle is driven and popped after the edge.
module tb_apu_envelope_unit;

    localparam int VOL_W = 4;

    logic             aclk1;
    logic             n_res;
    logic             wr_reg0;
    logic             wr_reg3;
    logic [5:0]       din;
    logic             qframe;
    logic [VOL_W-1:0] vol;
    logic             loop_q;

    logic [VOL_W:0] exp_q[$];
    int checks;
    int failures;

    apu_envelope_unit #(.VOL_W(VOL_W)) dut (
        .ACLK1   (aclk1),
        .n_res   (n_res),
        .wr_reg0 (wr_reg0),
        .wr_reg3 (wr_reg3),
        .din     (din),
        .qframe  (qframe),
        .vol     (vol),
        .loop_q  (loop_q)
    );

    // clock / reset
    initial aclk1 = 1'b0;
    always #5 aclk1 = ~aclk1;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [VOL_W:0] ev(input logic lp, input int v);
        logic [VOL_W-1:0] t;
        t = v[VOL_W-1:0];
        return {lp, t};
    endfunction

    // One ACLK1 cycle: drive on negedge, sample 1 ns after the rising edge.
    task automatic drive_step(input string tag, input logic w0, input logic w3, input logic qf,
                              input logic [5:0] d, input logic chk, input logic [VOL_W:0] exp);
        logic [VOL_W:0] e;
        @(negedge aclk1);
        wr_reg0 = w0;
        wr_reg3 = w3;
        qframe  = qf;
        din     = d;
        if (chk) exp_q.push_back(exp);
        @(posedge aclk1);
        #1;
        wr_reg0 = 1'b0;
        wr_reg3 = 1'b0;
        qframe  = 1'b0;
        if (chk) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, "_queue"}, 8'd0, 8'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq(tag, {3'b0, loop_q, vol}, {3'b0, e});
            end
        end
    endtask

    initial begin
        int e;
        checks   = 0;
        failures = 0;
        n_res    = 1'b0;
        wr_reg0  = 1'b0;
        wr_reg3  = 1'b0;
        qframe   = 1'b0;
        din      = 6'h00;

        // Reset state, then idle qframes
        #3;
        check_eq("reset", {3'b0, loop_q, vol}, 8'h00);
        @(negedge aclk1);
        n_res = 1'b1;
        for (int k = 0; k < 10; k++) drive_step("idle", 0, 0, 1, 6'h00, 1, ev(0, 0));

        // Decay: V=2, no loop; period 3 qframes, bottoms out and holds
        drive_step("decay_wr0", 1, 0, 0, 6'h02, 1, ev(0, 0));
        drive_step("decay_wr3", 0, 1, 0, 6'h02, 1, ev(0, 0));
        for (int k = 1; k <= 50; k++) begin
            e = 15 - (k - 1) / 3;
            if (e < 0) e = 0;
            drive_step("decay", 0, 0, 1, 6'h02, 1, ev(0, e));
        end

        // Loop: V=0, loop=1; wraps 0 -> 15
        drive_step("loop_wr0", 1, 0, 0, 6'h20, 1, ev(1, 0));
        drive_step("loop_wr3", 0, 1, 0, 6'h20, 1, ev(1, 0));
        for (int k = 1; k <= 17; k++) drive_step("loop", 0, 0, 1, 6'h20, 1, ev(1, (16 - k) & 15));

        // Constant volume ignores qframes; rewrite takes effect next cycle
        drive_step("const_wr", 1, 0, 0, 6'h17, 1, ev(0, 7));
        for (int k = 0; k < 3; k++) drive_step("const_qf", 0, 0, 1, 6'h17, 1, ev(0, 7));
        drive_step("const_rewr", 1, 0, 0, 6'h13, 1, ev(0, 3));

        // Collision of wr_reg3 with qframe at decay=5
        drive_step("col_wr0", 1, 0, 0, 6'h00, 0, '0);
        drive_step("col_wr3", 0, 1, 0, 6'h00, 0, '0);
        drive_step("col_start", 0, 0, 1, 6'h00, 1, ev(0, 15));
        for (int k = 14; k >= 5; k--) drive_step("col_pre", 0, 0, 1, 6'h00, 1, ev(0, k));
        drive_step("col_same", 0, 1, 1, 6'h00, 1, ev(0, 4));
        drive_step("col_reload", 0, 0, 1, 6'h00, 1, ev(0, 15));

        // wr_reg0 with qframe: old V=0 used on that edge, new V=5 afterwards
        drive_step("wq_same", 1, 0, 1, 6'h05, 1, ev(0, 14));
        drive_step("wq_next", 0, 0, 1, 6'h05, 1, ev(0, 13));
        for (int k = 0; k < 5; k++) drive_step("wq_hold", 0, 0, 1, 6'h05, 1, ev(0, 13));
        drive_step("wq_step", 0, 0, 1, 6'h05, 1, ev(0, 12));

        // Async reset mid-decay at vol=9
        drive_step("rst_wr0", 1, 0, 0, 6'h00, 0, '0);
        drive_step("rst_wr3", 0, 1, 0, 6'h00, 0, '0);
        drive_step("rst_start", 0, 0, 1, 6'h00, 1, ev(0, 15));
        for (int k = 14; k >= 9; k--) drive_step("rst_pre", 0, 0, 1, 6'h00, 1, ev(0, k));
        #1;
        n_res = 1'b0;
        #1;
        check_eq("rst_async", {3'b0, loop_q, vol}, 8'h00);
        @(negedge aclk1);
        n_res = 1'b1;
        for (int k = 0; k < 5; k++) drive_step("rst_idle", 0, 0, 1, 6'h00, 1, ev(0, 0));
        drive_step("rst_wr3b", 0, 1, 0, 6'h00, 1, ev(0, 0));
        drive_step("rst_restart", 0, 0, 1, 6'h00, 1, ev(0, 15));

        check_eq("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
